// File: rtl/ras_ckpt.sv
// Return address stack on a circular buffer with per-entry recursion counters
// and speculative top-of-stack checkpoints for misprediction recovery.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module ras_ckpt #(
   parameter int DEPTH     = 16,
   parameter int CNT_WIDTH = 8,
   parameter int CKPT_NUM  = 8
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [`ADDR_WIDTH-1:0]                   bp_ras_addr,
   input  logic                                     bp_ras_push,
   input  logic                                     bp_ras_pop,
   output logic [`ADDR_WIDTH-1:0]                   ras_bp_addr,
   output logic                                     ras_bp_valid,
   input  logic                                     bp_ras_ckpt_save,
   input  logic [((CKPT_NUM > 1) ? $clog2(CKPT_NUM) : 1)-1:0] bp_ras_ckpt_save_id,
   input  logic                                     commit_ras_ckpt_restore,
   input  logic [((CKPT_NUM > 1) ? $clog2(CKPT_NUM) : 1)-1:0] commit_ras_ckpt_restore_id,
   output logic                                     ras_csrf_ras_full_add,
   output logic                                     ras_csrf_ras_underflow_add
);

   localparam int AW = `ADDR_WIDTH;
   localparam int IW = $clog2(DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [IW:0]          OCC_FULL = (IW+1)'(DEPTH);

   logic [AW-1:0]        buf_addr [DEPTH];
   logic [CNT_WIDTH-1:0] buf_cnt  [DEPTH];
   logic [IW-1:0]        top_idx;
   logic [IW:0]          occ;

   logic [IW-1:0]        ckpt_idx  [CKPT_NUM];
   logic [IW:0]          ckpt_occ  [CKPT_NUM];
   logic [AW-1:0]        ckpt_addr [CKPT_NUM];
   logic [CNT_WIDTH-1:0] ckpt_cnt  [CKPT_NUM];

   logic [AW-1:0]        top_addr;
   logic [CNT_WIDTH-1:0] top_cnt;
   logic [IW-1:0]        nxt_idx;
   logic                 empty;
   logic                 full;
   logic                 hit;

   logic [IW-1:0]        top_idx_n;
   logic [IW:0]          occ_n;
   logic                 top_we;
   logic [AW-1:0]        top_addr_n;
   logic [CNT_WIDTH-1:0] top_cnt_n;
   logic                 alloc;
   logic                 full_add;
   logic                 underflow_add;

   assign top_addr = buf_addr[top_idx];
   assign top_cnt  = buf_cnt[top_idx];
   assign nxt_idx  = top_idx + 1'b1;
   assign empty    = (occ == '0);
   assign full     = (occ == OCC_FULL);
   assign hit      = !empty && (bp_ras_addr == top_addr);

   assign ras_bp_valid = !empty;
   assign ras_bp_addr  = empty ? '0 : top_addr;

   // Pulses stay quiet while reset is asserted, even with a request present.
   assign ras_csrf_ras_full_add      = rst & full_add;
   assign ras_csrf_ras_underflow_add = rst & underflow_add;

   always_comb begin
      top_idx_n     = top_idx;
      occ_n         = occ;
      top_we        = 1'b0;
      top_addr_n    = top_addr;
      top_cnt_n     = top_cnt;
      alloc         = 1'b0;
      full_add      = 1'b0;
      underflow_add = 1'b0;
      if (commit_ras_ckpt_restore) begin
         top_idx_n = ckpt_idx[commit_ras_ckpt_restore_id];
         occ_n     = ckpt_occ[commit_ras_ckpt_restore_id];
      end else if (bp_ras_push && bp_ras_pop) begin
         if (empty) begin
            alloc = 1'b1;
         end else if (hit) begin
            alloc = 1'b0;
         end else if (top_cnt > CNT_ONE) begin
            top_we    = 1'b1;
            top_cnt_n = top_cnt - CNT_ONE;
            alloc     = 1'b1;
         end else begin
            top_we     = 1'b1;
            top_addr_n = bp_ras_addr;
            top_cnt_n  = CNT_ONE;
         end
      end else if (bp_ras_push) begin
         if (hit && (top_cnt != CNT_MAX)) begin
            top_we    = 1'b1;
            top_cnt_n = top_cnt + CNT_ONE;
         end else begin
            alloc = 1'b1;
         end
      end else if (bp_ras_pop) begin
         if (empty) begin
            underflow_add = 1'b1;
         end else if (top_cnt > CNT_ONE) begin
            top_we    = 1'b1;
            top_cnt_n = top_cnt - CNT_ONE;
         end else begin
            top_idx_n = top_idx - 1'b1;
            occ_n     = occ - 1'b1;
         end
      end
      // On a full stack the slot after top is the oldest entry; overwrite it.
      if (alloc) begin
         top_idx_n = nxt_idx;
         if (full) begin
            full_add = 1'b1;
         end else begin
            occ_n = occ + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         top_idx <= '0;
         occ     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_addr[i] <= '0;
            buf_cnt[i]  <= '0;
         end
         for (int i = 0; i < CKPT_NUM; i++) begin
            ckpt_idx[i]  <= '0;
            ckpt_occ[i]  <= '0;
            ckpt_addr[i] <= '0;
            ckpt_cnt[i]  <= '0;
         end
      end else begin
         top_idx <= top_idx_n;
         occ     <= occ_n;
         if (commit_ras_ckpt_restore) begin
            buf_addr[ckpt_idx[commit_ras_ckpt_restore_id]] <= ckpt_addr[commit_ras_ckpt_restore_id];
            buf_cnt[ckpt_idx[commit_ras_ckpt_restore_id]]  <= ckpt_cnt[commit_ras_ckpt_restore_id];
         end else begin
            if (top_we) begin
               buf_addr[top_idx] <= top_addr_n;
               buf_cnt[top_idx]  <= top_cnt_n;
            end
            if (alloc) begin
               buf_addr[nxt_idx] <= bp_ras_addr;
               buf_cnt[nxt_idx]  <= CNT_ONE;
            end
            if (bp_ras_ckpt_save) begin
               ckpt_idx[bp_ras_ckpt_save_id]  <= top_idx;
               ckpt_occ[bp_ras_ckpt_save_id]  <= occ;
               ckpt_addr[bp_ras_ckpt_save_id] <= top_addr;
               ckpt_cnt[bp_ras_ckpt_save_id]  <= top_cnt;
            end
         end
      end
   end

endmodule

// File: tb/tb_ras_ckpt.sv
// Scoreboard bench for ras_ckpt: each op queues its expected pulses and
// post-edge top-of-stack, which are popped and compared once the DUT responds.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_ras_ckpt;

   localparam int AW    = `ADDR_WIDTH;
   localparam int DEPTH = 16;
   localparam int CNTW  = 8;
   localparam int CKPTN = 8;
   localparam int SW    = 3;

   typedef struct {
      logic          r, pu, po, sv, rs;
      logic [SW-1:0] sid, rid;
      logic [AW-1:0] a;
      logic [1:0]    exp_p;
      logic          exp_v;
      logic [AW-1:0] exp_a;
   } op_t;

   typedef struct {
      logic [1:0]    p;
      logic          v;
      logic [AW-1:0] a;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] bp_ras_addr;
   logic          bp_ras_push, bp_ras_pop;
   logic [AW-1:0] ras_bp_addr;
   logic          ras_bp_valid;
   logic          bp_ras_ckpt_save, commit_ras_ckpt_restore;
   logic [SW-1:0] bp_ras_ckpt_save_id, commit_ras_ckpt_restore_id;
   logic          ras_csrf_ras_full_add, ras_csrf_ras_underflow_add;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   logic [1:0]    obs_p;
   logic          obs_v;
   logic [AW-1:0] obs_a;

   ras_ckpt #(.DEPTH(DEPTH), .CNT_WIDTH(CNTW), .CKPT_NUM(CKPTN)) dut (
      .clk                        (clk),
      .rst                        (rst),
      .bp_ras_addr                (bp_ras_addr),
      .bp_ras_push                (bp_ras_push),
      .bp_ras_pop                 (bp_ras_pop),
      .ras_bp_addr                (ras_bp_addr),
      .ras_bp_valid               (ras_bp_valid),
      .bp_ras_ckpt_save           (bp_ras_ckpt_save),
      .bp_ras_ckpt_save_id        (bp_ras_ckpt_save_id),
      .commit_ras_ckpt_restore    (commit_ras_ckpt_restore),
      .commit_ras_ckpt_restore_id (commit_ras_ckpt_restore_id),
      .ras_csrf_ras_full_add      (ras_csrf_ras_full_add),
      .ras_csrf_ras_underflow_add (ras_csrf_ras_underflow_add)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got=running want=finished");
      $fatal(1);
   end

   function automatic op_t mk(input logic r, input logic pu, input logic po,
                              input logic [AW-1:0] a, input logic sv, input int sid,
                              input logic rs, input int rid, input logic [1:0] p,
                              input logic v, input logic [AW-1:0] ea);
      op_t o;
      o.r = r; o.pu = pu; o.po = po; o.a = a;
      o.sv = sv; o.sid = SW'(sid); o.rs = rs; o.rid = SW'(rid);
      o.exp_p = p; o.exp_v = v; o.exp_a = ea;
      return o;
   endfunction

   function automatic op_t opu(input logic [AW-1:0] a, input logic fa, input logic [AW-1:0] ea);
      return mk(1'b1, 1'b1, 1'b0, a, 1'b0, 0, 1'b0, 0, {fa, 1'b0}, 1'b1, ea);
   endfunction

   function automatic op_t opo(input logic uf, input logic v, input logic [AW-1:0] ea);
      return mk(1'b1, 1'b0, 1'b1, '0, 1'b0, 0, 1'b0, 0, {1'b0, uf}, v, ea);
   endfunction

   // Drives one cycle of stimulus, queues its expectation, samples the pulses
   // before the edge and the top-of-stack after it.
   task automatic apply(input op_t o);
      @(negedge clk);
      rst = o.r; bp_ras_push = o.pu; bp_ras_pop = o.po; bp_ras_addr = o.a;
      bp_ras_ckpt_save = o.sv; bp_ras_ckpt_save_id = o.sid;
      commit_ras_ckpt_restore = o.rs; commit_ras_ckpt_restore_id = o.rid;
      sb.push_back('{p: o.exp_p, v: o.exp_v, a: o.exp_a});
      #1;
      obs_p = {ras_csrf_ras_full_add, ras_csrf_ras_underflow_add};
      @(posedge clk);
      #1;
      obs_v = ras_bp_valid;
      obs_a = ras_bp_addr;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b0; bp_ras_push = 1'b0; bp_ras_pop = 1'b0; bp_ras_addr = '0;
      bp_ras_ckpt_save = 1'b0; commit_ras_ckpt_restore = 1'b0;
      bp_ras_ckpt_save_id = '0; commit_ras_ckpt_restore_id = '0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      op_t  ops[$];
      exp_t e;
      ops.push_back(mk(1'b0, 1'b1, 1'b0, 32'h55, 1'b0, 0, 1'b0, 0, 2'b00, 1'b0, '0));
      ops.push_back(mk(1'b1, 1'b0, 1'b0, '0, 1'b0, 0, 1'b0, 0, 2'b00, 1'b0, '0));
      foreach (ops[i]) begin
         apply(ops[i]);
         e = sb.pop_front();
         checks++;
         if (obs_p !== e.p) begin
            failures++;
            $display("FAIL reset[%0d] pulses got=%b want=%b", i, obs_p, e.p);
         end
         checks++;
         if ({obs_v, obs_a} !== {e.v, e.a}) begin
            failures++;
            $display("FAIL reset[%0d] top got=%b/%h want=%b/%h", i, obs_v, obs_a, e.v, e.a);
         end
      end
   endtask

   task automatic test_basic();
      op_t  ops[$];
      exp_t e;
      reset_dut();
      ops.push_back(opu(32'h100, 1'b0, 32'h100));
      ops.push_back(opu(32'h200, 1'b0, 32'h200));
      ops.push_back(opu(32'h300, 1'b0, 32'h300));
      ops.push_back(opo(1'b0, 1'b1, 32'h200));
      ops.push_back(opo(1'b0, 1'b1, 32'h100));
      ops.push_back(opo(1'b0, 1'b0, '0));
      ops.push_back(opo(1'b1, 1'b0, '0));
      ops.push_back(mk(1'b1, 1'b0, 1'b0, '0, 1'b0, 0, 1'b0, 0, 2'b00, 1'b0, '0));
      ops.push_back(opu(32'h400, 1'b0, 32'h400));
      foreach (ops[i]) begin
         apply(ops[i]);
         e = sb.pop_front();
         checks++;
         if (obs_p !== e.p) begin
            failures++;
            $display("FAIL basic[%0d] pulses got=%b want=%b", i, obs_p, e.p);
         end
         checks++;
         if ({obs_v, obs_a} !== {e.v, e.a}) begin
            failures++;
            $display("FAIL basic[%0d] top got=%b/%h want=%b/%h", i, obs_v, obs_a, e.v, e.a);
         end
      end
   endtask

   task automatic test_recursion();
      op_t  ops[$];
      exp_t e;
      reset_dut();
      for (int k = 0; k < 5; k++) ops.push_back(opu(32'h40, 1'b0, 32'h40));
      for (int k = 0; k < 4; k++) ops.push_back(opo(1'b0, 1'b1, 32'h40));
      ops.push_back(opo(1'b0, 1'b0, '0));
      // 255 identical pushes saturate one entry; the next one allocates.
      for (int k = 0; k < 256; k++) ops.push_back(opu(32'h40, 1'b0, 32'h40));
      for (int k = 0; k < 255; k++) ops.push_back(opo(1'b0, 1'b1, 32'h40));
      ops.push_back(opo(1'b0, 1'b0, '0));
      foreach (ops[i]) begin
         apply(ops[i]);
         e = sb.pop_front();
         checks++;
         if (obs_p !== e.p) begin
            failures++;
            $display("FAIL recursion[%0d] pulses got=%b want=%b", i, obs_p, e.p);
         end
         checks++;
         if ({obs_v, obs_a} !== {e.v, e.a}) begin
            failures++;
            $display("FAIL recursion[%0d] top got=%b/%h want=%b/%h", i, obs_v, obs_a, e.v, e.a);
         end
      end
   endtask

   task automatic test_overflow();
      op_t  ops[$];
      exp_t e;
      reset_dut();
      for (int k = 1; k <= DEPTH + 1; k++)
         ops.push_back(opu(AW'(k * 16), (k == DEPTH + 1), AW'(k * 16)));
      for (int k = 1; k < DEPTH; k++)
         ops.push_back(opo(1'b0, 1'b1, AW'((DEPTH + 1 - k) * 16)));
      ops.push_back(opo(1'b0, 1'b0, '0));
      foreach (ops[i]) begin
         apply(ops[i]);
         e = sb.pop_front();
         checks++;
         if (obs_p !== e.p) begin
            failures++;
            $display("FAIL overflow[%0d] pulses got=%b want=%b", i, obs_p, e.p);
         end
         checks++;
         if ({obs_v, obs_a} !== {e.v, e.a}) begin
            failures++;
            $display("FAIL overflow[%0d] top got=%b/%h want=%b/%h", i, obs_v, obs_a, e.v, e.a);
         end
      end
   endtask

   task automatic test_push_pop();
      op_t  ops[$];
      exp_t e;
      int   seg[$];
      ops.push_back(opu(32'h10, 1'b0, 32'h10));
      ops.push_back(opu(32'h20, 1'b0, 32'h20));
      ops.push_back(mk(1'b1, 1'b1, 1'b1, 32'h30, 1'b0, 0, 1'b0, 0, 2'b00, 1'b1, 32'h30));
      ops.push_back(opo(1'b0, 1'b1, 32'h10));
      ops.push_back(opo(1'b0, 1'b0, '0));
      seg.push_back(ops.size());
      ops.push_back(opu(32'h10, 1'b0, 32'h10));
      ops.push_back(opu(32'h20, 1'b0, 32'h20));
      ops.push_back(opu(32'h20, 1'b0, 32'h20));
      ops.push_back(mk(1'b1, 1'b1, 1'b1, 32'h30, 1'b0, 0, 1'b0, 0, 2'b00, 1'b1, 32'h30));
      ops.push_back(opo(1'b0, 1'b1, 32'h20));
      ops.push_back(opo(1'b0, 1'b1, 32'h10));
      ops.push_back(opo(1'b0, 1'b0, '0));
      seg.push_back(ops.size());
      ops.push_back(opu(32'h10, 1'b0, 32'h10));
      ops.push_back(mk(1'b1, 1'b1, 1'b1, 32'h10, 1'b0, 0, 1'b0, 0, 2'b00, 1'b1, 32'h10));
      ops.push_back(opo(1'b0, 1'b0, '0));
      seg.push_back(ops.size());
      ops.push_back(mk(1'b1, 1'b1, 1'b1, 32'h77, 1'b0, 0, 1'b0, 0, 2'b00, 1'b1, 32'h77));
      ops.push_back(opo(1'b0, 1'b0, '0));
      reset_dut();
      foreach (ops[i]) begin
         if (seg.size() != 0 && seg[0] == i) begin
            void'(seg.pop_front());
            reset_dut();
         end
         apply(ops[i]);
         e = sb.pop_front();
         checks++;
         if (obs_p !== e.p) begin
            failures++;
            $display("FAIL push_pop[%0d] pulses got=%b want=%b", i, obs_p, e.p);
         end
         checks++;
         if ({obs_v, obs_a} !== {e.v, e.a}) begin
            failures++;
            $display("FAIL push_pop[%0d] top got=%b/%h want=%b/%h", i, obs_v, obs_a, e.v, e.a);
         end
      end
   endtask

   task automatic test_checkpoint();
      op_t  ops[$];
      exp_t e;
      reset_dut();
      ops.push_back(opu(32'h10, 1'b0, 32'h10));
      ops.push_back(opu(32'h20, 1'b0, 32'h20));
      ops.push_back(mk(1'b1, 1'b0, 1'b0, '0, 1'b1, 3, 1'b0, 0, 2'b00, 1'b1, 32'h20));
      ops.push_back(opu(32'h30, 1'b0, 32'h30));
      ops.push_back(opu(32'h40, 1'b0, 32'h40));
      ops.push_back(mk(1'b1, 1'b1, 1'b0, 32'h99, 1'b0, 0, 1'b1, 3, 2'b00, 1'b1, 32'h20));
      ops.push_back(opo(1'b0, 1'b1, 32'h10));
      ops.push_back(opo(1'b0, 1'b0, '0));
      // Save alongside a push snapshots the pre-push top.
      ops.push_back(opu(32'hA0, 1'b0, 32'hA0));
      ops.push_back(mk(1'b1, 1'b1, 1'b0, 32'hB0, 1'b1, 1, 1'b0, 0, 2'b00, 1'b1, 32'hB0));
      ops.push_back(opu(32'hC0, 1'b0, 32'hC0));
      ops.push_back(mk(1'b1, 1'b0, 1'b1, '0, 1'b0, 0, 1'b1, 1, 2'b00, 1'b1, 32'hA0));
      ops.push_back(opo(1'b0, 1'b0, '0));
      // Restore on empty with a pop pending must not flag underflow.
      ops.push_back(mk(1'b1, 1'b0, 1'b1, '0, 1'b0, 0, 1'b1, 3, 2'b00, 1'b1, 32'h20));
      foreach (ops[i]) begin
         apply(ops[i]);
         e = sb.pop_front();
         checks++;
         if (obs_p !== e.p) begin
            failures++;
            $display("FAIL checkpoint[%0d] pulses got=%b want=%b", i, obs_p, e.p);
         end
         checks++;
         if ({obs_v, obs_a} !== {e.v, e.a}) begin
            failures++;
            $display("FAIL checkpoint[%0d] top got=%b/%h want=%b/%h", i, obs_v, obs_a, e.v, e.a);
         end
      end
   endtask

   task automatic test_unused_and_midreset();
      op_t  ops[$];
      exp_t e;
      reset_dut();
      ops.push_back(opu(32'h11, 1'b0, 32'h11));
      ops.push_back(opu(32'h22, 1'b0, 32'h22));
      ops.push_back(mk(1'b1, 1'b0, 1'b0, '0, 1'b0, 0, 1'b1, 5, 2'b00, 1'b0, '0));
      ops.push_back(opu(32'h60, 1'b0, 32'h60));
      ops.push_back(opu(32'h70, 1'b0, 32'h70));
      ops.push_back(mk(1'b0, 1'b1, 1'b0, 32'h33, 1'b0, 0, 1'b0, 0, 2'b00, 1'b0, '0));
      ops.push_back(opo(1'b1, 1'b0, '0));
      foreach (ops[i]) begin
         apply(ops[i]);
         e = sb.pop_front();
         checks++;
         if (obs_p !== e.p) begin
            failures++;
            $display("FAIL unused_midreset[%0d] pulses got=%b want=%b", i, obs_p, e.p);
         end
         checks++;
         if ({obs_v, obs_a} !== {e.v, e.a}) begin
            failures++;
            $display("FAIL unused_midreset[%0d] top got=%b/%h want=%b/%h", i, obs_v, obs_a, e.v, e.a);
         end
      end
   endtask

   initial begin
      rst = 1'b0; bp_ras_push = 1'b0; bp_ras_pop = 1'b0; bp_ras_addr = '0;
      bp_ras_ckpt_save = 1'b0; commit_ras_ckpt_restore = 1'b0;
      bp_ras_ckpt_save_id = '0; commit_ras_ckpt_restore_id = '0;
      test_reset();
      test_basic();
      test_recursion();
      test_overflow();
      test_push_pop();
      test_checkpoint();
      test_unused_and_midreset();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain leftover got=%0d want=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
